// File: rtl/fencei_sequencer_pkg.sv
// Shared definitions for the FENCE.I memory-side sequencer: state encoding
// (also decoded by debug/trace logic) and the redirect step.
package fencei_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRAIN    = 3'd1,
    S_DC_FLUSH = 3'd2,
    S_IC_INV   = 3'd3,
    S_REDIRECT = 3'd4
  } fencei_state_e;

  localparam int unsigned PC_STEP = 4;

  // A zero-length drain still spends one cycle in DRAIN.
  function automatic int unsigned drain_len(input int unsigned cycles);
    return (cycles == 0) ? 1 : cycles;
  endfunction

endpackage

// File: rtl/fencei_sequencer.sv
// FENCE.I sequencer: stall the front end, drain, write back the D-cache,
// invalidate the I-cache, then redirect fetch to the instruction after FENCE.I.
module fencei_sequencer
  import fencei_sequencer_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            is_fencei_i,
  input  logic [XLEN-1:0] fencei_pc_i,
  input  logic            stall_i,
  input  logic            sys_jump_i,
  output logic            dc_flush_req_o,
  input  logic            dc_flush_done_i,
  output logic            ic_inv_req_o,
  input  logic            ic_inv_done_i,
  output logic            busy_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam int unsigned      CNT_W    = $clog2(DRAIN_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(drain_len(DRAIN_CYCLES));

  fencei_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [XLEN-1:0]  pc_q,   pc_d;
  logic [XLEN-1:0]  rpc_q,  rpc_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    rpc_d   = rpc_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_fencei_i && !stall_i && !sys_jump_i) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_LOAD;
          pc_d    = fencei_pc_i;
        end
      end
      S_DRAIN: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = S_DC_FLUSH;
      end
      S_DC_FLUSH: begin
        if (dc_flush_done_i) state_d = S_IC_INV;
      end
      S_IC_INV: begin
        // Target is captured on entry to REDIRECT so it stays 0 until the first redirect.
        if (ic_inv_done_i) begin
          state_d = S_REDIRECT;
          rpc_d   = pc_q + XLEN'(PC_STEP);
        end
      end
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  assign busy_o         = (state_q != S_IDLE);
  assign dc_flush_req_o = (state_q == S_DC_FLUSH);
  assign ic_inv_req_o   = (state_q == S_IC_INV);
  assign redirect_o     = (state_q == S_REDIRECT);
  assign redirect_pc_o  = rpc_q;

endmodule
